sync_fifo_ctrl: RTL and testbench

//  - Single-clock FIFO controller that sequences the dual-port storage array (mem).
//  - Owns read/write pointers, full/empty, occupancy count and almost-full/empty thresholds.
//  - Drives the array's write enable, write address and read address.
//  - Reads are first-word-fall-through: the head entry is valid on the array's r_data whenever r_empty=0.

---
 rtl/fifo_pkg.sv | 43 ++++
 rtl/sync_fifo_ctrl_if.sv | 53 +++++
 rtl/fifo_ptr.sv | 36 +++
 rtl/sync_fifo_ctrl.sv | 88 ++++++++
 tb/tb_sync_fifo_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types and pointer helpers for the sync_fifo_ctrl FIFO controller.
//  - fifo_err_t : sticky error flags {overflow, underflow} (used when
//                 SYNC_FIFO_CTRL_ERR_EN is defined)
//  - ptr_inc()  : pointer increment with wrap at 2^(addr_width+1)
//  - is_full()  : full test on two wrap-bit pointers
// Pointers are passed zero-extended to PTR_MAX_W bits so one function serves
// every ADDR_WIDTH; callers size-cast the result back to their pointer width.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int PTR_MAX_W = 32;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic logic [PTR_MAX_W-1:0] ptr_inc(
        input logic [PTR_MAX_W-1:0] ptr,
        input int                   addr_width
    );
        logic [PTR_MAX_W-1:0] mask;
        mask = (PTR_MAX_W'(1) << (addr_width + 1)) - PTR_MAX_W'(1);
        return (ptr + PTR_MAX_W'(1)) & mask;
    endfunction

    // Full when the wrap bits differ and the address bits match.
    function automatic logic is_full(
        input logic [PTR_MAX_W-1:0] wptr,
        input logic [PTR_MAX_W-1:0] rptr,
        input int                   addr_width
    );
        logic [PTR_MAX_W-1:0] diff;
        logic [PTR_MAX_W-1:0] low_mask;
        diff     = wptr ^ rptr;
        low_mask = (PTR_MAX_W'(1) << addr_width) - PTR_MAX_W'(1);
        return (((diff >> addr_width) & PTR_MAX_W'(1)) != '0) &&
               ((diff & low_mask) == '0);
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl_if
// Handshake and array-control bundle between a FIFO user and sync_fifo_ctrl.
//  - w_inc, r_inc               : push / pop requests (from master)
//  - w_full, r_empty            : status flags (from slave)
//  - mem_we, w_addr, r_addr     : storage array control (from slave)
//  - count, almost_full/empty   : occupancy and thresholds (from slave)
//  - overflow, underflow        : sticky error flags, present only when
//                                 SYNC_FIFO_CTRL_ERR_EN is defined
// Modports: slave = the controller, master = the requesting side.
// -----------------------------------------------------------------------------
interface sync_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  w_inc;
    logic                  r_inc;
    logic                  w_full;
    logic                  r_empty;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   count;
    logic                  almost_full;
    logic                  almost_empty;
`ifdef SYNC_FIFO_CTRL_ERR_EN
    logic                  overflow;
    logic                  underflow;

    modport slave (
        input  w_inc, r_inc,
        output w_full, r_empty, mem_we, w_addr, r_addr, count,
               almost_full, almost_empty, overflow, underflow
    );

    modport master (
        output w_inc, r_inc,
        input  w_full, r_empty, mem_we, w_addr, r_addr, count,
               almost_full, almost_empty, overflow, underflow
    );
`else
    modport slave (
        input  w_inc, r_inc,
        output w_full, r_empty, mem_we, w_addr, r_addr, count,
               almost_full, almost_empty
    );

    modport master (
        output w_inc, r_inc,
        input  w_full, r_empty, mem_we, w_addr, r_addr, count,
               almost_full, almost_empty
    );
`endif
endinterface

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// One FIFO pointer of ADDR_WIDTH+1 bits (MSB = wrap bit), advancing by one
// with wrap whenever i_en is high.
//  - clk   : clock
//  - rst   : asynchronous active-high reset, pointer -> 0
//  - i_en  : advance the pointer at this edge
//  - o_ptr : registered pointer value
// -----------------------------------------------------------------------------
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    output logic [ADDR_WIDTH:0] o_ptr
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH:0] r_ptr;
    logic [ADDR_WIDTH:0] w_next;

    assign w_next = PW'(ptr_inc(PTR_MAX_W'(r_ptr), ADDR_WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= w_next;
        end
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
// Single-clock first-word-fall-through FIFO controller. Owns the read/write
// pointers and derives full/empty, occupancy and almost-full/empty from them;
// drives write enable and both addresses of an external dual-port array.
//  - clk  : clock, all logic on posedge
//  - rst  : asynchronous active-high reset
//  - bus  : sync_fifo_ctrl_if.slave (w_inc, r_inc in; w_full, r_empty,
//           mem_we, w_addr, r_addr, count, almost_full, almost_empty out)
// Optional: define SYNC_FIFO_CTRL_ERR_EN to add sticky overflow/underflow
// outputs on the interface. Without it, rejected requests are dropped silently.
// -----------------------------------------------------------------------------
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_ctrl_if.slave  bus
);
    localparam int                  PW     = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] AF_LVL = PW'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_LVL = PW'(AE_LEVEL);

    logic [ADDR_WIDTH:0] w_wptr;
    logic [ADDR_WIDTH:0] w_rptr;
    logic [ADDR_WIDTH:0] w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_wr_ok;
    logic                w_rd_ok;

    // Flags come straight from the registered pointers, so a simultaneous
    // read and write at full/empty is judged on the pre-edge state.
    assign w_empty = (w_wptr == w_rptr);
    assign w_full  = is_full(PTR_MAX_W'(w_wptr), PTR_MAX_W'(w_rptr), ADDR_WIDTH);
    assign w_count = w_wptr - w_rptr;   // modulo 2^(ADDR_WIDTH+1) covers wrap

    assign w_wr_ok = bus.w_inc & ~w_full;
    assign w_rd_ok = bus.r_inc & ~w_empty;

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_wr_ok),
        .o_ptr (w_wptr)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_rd_ok),
        .o_ptr (w_rptr)
    );

    assign bus.w_full       = w_full;
    assign bus.r_empty      = w_empty;
    assign bus.mem_we       = w_wr_ok;
    assign bus.w_addr       = w_wptr[ADDR_WIDTH-1:0];
    assign bus.r_addr       = w_rptr[ADDR_WIDTH-1:0];
    assign bus.count        = w_count;
    assign bus.almost_full  = (w_count >= AF_LVL);
    assign bus.almost_empty = (w_count <= AE_LVL);

`ifdef SYNC_FIFO_CTRL_ERR_EN
    fifo_err_t r_err;

    // Sticky until reset; set on the edge following the offending request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            if (bus.w_inc && w_full) begin
                r_err.overflow <= 1'b1;
            end
            if (bus.r_inc && w_empty) begin
                r_err.underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_err.overflow;
    assign bus.underflow = r_err.underflow;
`endif
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ctrl
// Self-checking bench for sync_fifo_ctrl. The bench owns the storage array
// (written on mem_we, read combinationally at r_addr) and a reference model of
// occupancy and pointers; pushed data goes to a scoreboard queue and is popped
// and compared against r_data whenever a read is accepted.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ctrl;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_ctrl_if #(.ADDR_WIDTH(AW)) fif ();

    sync_fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (fif)
    );

    logic [7:0] mem [DEPTH];
    logic [7:0] wdata;
    logic [7:0] r_data;

    always @(posedge clk) begin
        if (fif.mem_we) mem[fif.w_addr] <= wdata;
    end
    assign r_data = mem[fif.r_addr];

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb [$];
    int         m_cnt   = 0;
    logic [AW:0] m_wptr = '0;
    logic [AW:0] m_rptr = '0;

    task automatic model_reset();
        sb.delete();
        m_cnt  = 0;
        m_wptr = '0;
        m_rptr = '0;
    endtask

    // One clock of stimulus: drive requests, compare the pre-edge outputs
    // (mem_we, FWFT head data), step the model, then compare post-edge state.
    task automatic do_cycle(input logic w, input logic r, input logic [7:0] d,
                            input string tag);
        logic       wr_ok;
        logic       rd_ok;
        logic [7:0] exp_d;
        logic [AW:0] exp_cnt;
        fif.w_inc = w;
        fif.r_inc = r;
        wdata     = d;
        #1;
        wr_ok = w && (m_cnt != DEPTH);
        rd_ok = r && (m_cnt != 0);
        n_tests++;
        if (fif.mem_we !== wr_ok) begin
            n_fail++;
            $display("FAIL %s mem_we: got %b expected %b", tag, fif.mem_we, wr_ok);
        end
        if (rd_ok) begin
            exp_d = sb.pop_front();
            n_tests++;
            if (r_data !== exp_d) begin
                n_fail++;
                $display("FAIL %s r_data: got %h expected %h", tag, r_data, exp_d);
            end
        end
        if (wr_ok) sb.push_back(d);
        @(posedge clk);
        #1;
        fif.w_inc = 1'b0;
        fif.r_inc = 1'b0;
        if (wr_ok) begin m_wptr = m_wptr + 1'b1; m_cnt++; end
        if (rd_ok) begin m_rptr = m_rptr + 1'b1; m_cnt--; end
        exp_cnt = m_cnt[AW:0];
        n_tests++;
        if (fif.count !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s count: got %0d expected %0d", tag, fif.count, exp_cnt);
        end
        n_tests++;
        if (fif.r_empty !== (m_cnt == 0) || fif.w_full !== (m_cnt == DEPTH)) begin
            n_fail++;
            $display("FAIL %s empty/full: got %b/%b expected %b/%b", tag,
                     fif.r_empty, fif.w_full, (m_cnt == 0), (m_cnt == DEPTH));
        end
        n_tests++;
        if (fif.almost_full !== (m_cnt >= AF) || fif.almost_empty !== (m_cnt <= AE)) begin
            n_fail++;
            $display("FAIL %s af/ae: got %b/%b expected %b/%b", tag,
                     fif.almost_full, fif.almost_empty, (m_cnt >= AF), (m_cnt <= AE));
        end
        n_tests++;
        if (fif.w_addr !== m_wptr[AW-1:0] || fif.r_addr !== m_rptr[AW-1:0]) begin
            n_fail++;
            $display("FAIL %s addr: got w%0d r%0d expected w%0d r%0d", tag,
                     fif.w_addr, fif.r_addr, m_wptr[AW-1:0], m_rptr[AW-1:0]);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        fif.w_inc = 1'b0;
        fif.r_inc = 1'b0;
        wdata     = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (fif.count !== '0 || fif.r_empty !== 1'b1 || fif.w_full !== 1'b0 ||
            fif.almost_full !== 1'b0 || fif.almost_empty !== 1'b1 || fif.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got cnt=%0d e=%b f=%b af=%b ae=%b we=%b expected 0 1 0 0 1 0",
                     fif.count, fif.r_empty, fif.w_full, fif.almost_full,
                     fif.almost_empty, fif.mem_we);
        end
        n_tests++;
        if (fif.w_addr !== '0 || fif.r_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got w%0d r%0d expected 0 0", fif.w_addr, fif.r_addr);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, 8'(i), "fill");
        do_cycle(1'b1, 1'b0, 8'hFF, "fill_17th");
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 1'b1, 8'h00, "drain");
        do_cycle(1'b0, 1'b1, 8'h00, "drain_extra");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 8'(8'h20 + i), "b2b_pre");
        for (int i = 0; i < 40; i++) do_cycle(1'b1, 1'b1, 8'(8'h40 + i), "b2b");
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b1, 8'h00, "b2b_post");
    endtask

    task automatic test_boundary();
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, 8'(8'h80 + i), "bnd_fill");
        do_cycle(1'b1, 1'b1, 8'h99, "full_rw");
        for (int i = 0; i < DEPTH - 1; i++) do_cycle(1'b0, 1'b1, 8'h00, "bnd_drain");
        do_cycle(1'b1, 1'b1, 8'h77, "empty_rw");
        do_cycle(1'b0, 1'b1, 8'h00, "empty_rw_read");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b0, 8'(8'h50 + i), "ar_fill");
        fif.w_inc = 1'b1;
        wdata     = 8'h60;
        #3;
        rst       = 1'b1;
        fif.w_inc = 1'b0;
        #1;
        n_tests++;
        if (fif.count !== '0 || fif.r_empty !== 1'b1 || fif.w_full !== 1'b0 ||
            fif.almost_full !== 1'b0 || fif.almost_empty !== 1'b1 || fif.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got cnt=%0d e=%b f=%b af=%b ae=%b we=%b expected 0 1 0 0 1 0",
                     fif.count, fif.r_empty, fif.w_full, fif.almost_full,
                     fif.almost_empty, fif.mem_we);
        end
        n_tests++;
        if (fif.w_addr !== '0 || fif.r_addr !== '0) begin
            n_fail++;
            $display("FAIL async_reset_addr: got w%0d r%0d expected 0 0", fif.w_addr, fif.r_addr);
        end
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_cycle(1'b1, 1'b0, 8'hA5, "ar_write");
        do_cycle(1'b0, 1'b1, 8'h00, "ar_read");
    endtask

`ifdef SYNC_FIFO_CTRL_ERR_EN
    task automatic test_err_flags();
        n_tests++;
        if (fif.overflow !== 1'b0 || fif.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL err_init: got ov=%b un=%b expected 0 0", fif.overflow, fif.underflow);
        end
        do_cycle(1'b0, 1'b1, 8'h00, "err_underflow");
        n_tests++;
        if (fif.underflow !== 1'b1 || fif.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL err_underflow: got ov=%b un=%b expected 0 1", fif.overflow, fif.underflow);
        end
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, 8'(i), "err_fill");
        do_cycle(1'b1, 1'b0, 8'hEE, "err_overflow");
        n_tests++;
        if (fif.overflow !== 1'b1 || fif.underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got ov=%b un=%b expected 1 1", fif.overflow, fif.underflow);
        end
        rst = 1'b1;
        #2;
        n_tests++;
        if (fif.overflow !== 1'b0 || fif.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got ov=%b un=%b expected 0 0", fif.overflow, fif.underflow);
        end
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_boundary();
        test_async_reset();
`ifdef SYNC_FIFO_CTRL_ERR_EN
        test_err_flags();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
